keypad_event_queue: RTL and testbench
=====================================

# keypad_event_queue

Buffers keypad presses between the keypad scanner / 100 Hz one-pulse path and the game RAM controller. Each press becomes one queued key event, and a held key generates auto-repeat events. Queued events are presented first-word-fall-through, so the game FSM can consume at most one per cycle without losing presses that arrive while it is busy (line clear, piece spawn). A sticky overflow flag reports events that were dropped because the queue was full.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- ADDR_W, 2, log2(DEPTH)
- REPEAT_DELAY, 50, cycles from press to first repeat event; 0 disables repeat
- REPEAT_RATE, 10, cycles between subsequent repeat events; ≥1
- CNT_W, 16, width of hold counter; must hold max(REPEAT_DELAY, REPEAT_RATE)

Ports:
- clk  in  1  system clock (clk_100 domain)
- rst_n  in  1  asynchronous, active-low reset
- key_in  in  4  current key code from keypad scan; valid while pressed_in=1
- pressed_in  in  1  level: a key is held; synchronous to clk
- pop  in  1  consumer takes head entry this cycle
- clr_overflow  in  1  clears sticky overflow
- key_out  out  4  head entry; 0 when empty
- valid  out  1  queue non-empty
- count  out  ADDR_W+1  number of stored entries, 0..DEPTH
- overflow  out  1  sticky: an event was dropped on a full queue

## Operation
- Registered state: pressed_d, key_d, hold counter hcnt, repeat phase flag rep, FIFO storage, rd/wr pointers (ADDR_W+1 bits, wrap modulo 2·DEPTH), overflow.
- Event generator FSM, states IDLE and HELD:
  - IDLE: pressed_in=1 → push key_in, hcnt←0, rep←0, go to HELD.
  - HELD, pressed_in=0 → IDLE; no event.
  - HELD, key_in≠key_d → new press: push key_in, hcnt←0, rep←0.
  - HELD, same key, REPEAT_DELAY=0 → hold only; no events.
  - HELD, same key, rep=0, hcnt=REPEAT_DELAY-1 → push key_d, hcnt←0, rep←1.
  - HELD, same key, rep=1, hcnt=REPEAT_RATE-1 → push key_d, hcnt←0.
  - HELD, same key, otherwise → hcnt+1, saturating at 2^CNT_W-1.
- key_d is loaded with key_in on every cycle where pressed_in=1.
- FIFO:
  - push with count<DEPTH → write at wr_ptr, wr_ptr+1.
  - pop with valid=1 → rd_ptr+1. pop with valid=0 is ignored.
  - push with count=DEPTH and no pop → event dropped, overflow←1.
  - push and pop in the same cycle when count=DEPTH → both accepted; count stays DEPTH; no overflow.
  - push and pop in the same cycle when count=0 → push accepted, pop ignored; count becomes 1.
  - count = wr_ptr − rd_ptr, taken mod 2^(ADDR_W+1). Full when pointer MSBs differ and the low bits are equal.
- overflow: a set and clr_overflow in the same cycle → overflow stays 1 (set wins).
- key_out = mem[rd_ptr] when valid=1, otherwise 4'h0. Output is combinational from registers.

## Timing
- Reset (rst_n=0, async): state IDLE, pointers 0, hcnt 0, rep 0, key_d 0, pressed_d 0, overflow 0 → key_out=0, valid=0, count=0.
- Release of reset is synchronous to the next clk edge. A key already held at reset release counts as a fresh press at the first edge.
- Latency: pressed_in first sampled high at edge N → entry written at edge N; valid=1 and key_out=key after edge N.
- With the key held constantly, repeat events land at edges N+REPEAT_DELAY, then N+REPEAT_DELAY+k·REPEAT_RATE for k≥1.
- pop at edge M → the next entry (or valid=0) is visible after edge M. Throughput is one push and one pop per cycle.
- Release mid-count: pressed_in=0 at edge R → no event at R. A re-press at R+1 is a new press with a full REPEAT_DELAY.
- Reset mid-operation discards all queued entries and clears the repeat state immediately.

## Test plan
- Single press: pressed_in 0→1 at edge 10 with key 4'h5, held 20 cycles, pop never asserted → exactly one entry; valid=1 from after edge 10, key_out=5, count=1.
- Auto-repeat: key 4'h2 pressed at edge 0, held 80 cycles, pop asserted whenever valid=1 → pops at edges 1, 51, 61, 71; 4 events total, each key 2; none at 81 after release.
- Key change while held: key 4'h1 at edge 0, key_in→4'h3 at edge 5 with pressed_in still 1 → entries 1 then 3; next repeat at edge 55 (key 3).
- Overflow: DEPTH=4, five separate presses (keys 1,2,3,4,5), no pop → count=4, overflow=1, entries 1..4 popped in order; clr_overflow pulse → overflow=0.
- Simultaneous push/pop: queue full, new press and pop in the same cycle → count stays 4, overflow=0, head advances. Queue empty, press and pop in the same cycle → count=1.
- Async reset: rst_n pulled low mid-cycle with count=3 → valid=0, count=0, key_out=0 without waiting for a clk edge. A held key after release yields one entry at the first edge.

Source files
------------

// File: rtl/keypad_event_queue_if.sv
// keypad_event_queue_if: key event producer/consumer bundle for keypad_event_queue
//   key_in/pressed_in  : scanner side, key code and held level
//   pop/clr_overflow   : consumer takes head entry / clears sticky overflow
//   key_out/valid/count: FWFT head entry, non-empty flag, occupancy
//   overflow           : sticky drop indicator
interface keypad_event_queue_if #(parameter int ADDR_W = 2);
  logic [3:0]    key_in;
  logic          pressed_in;
  logic          pop;
  logic          clr_overflow;
  logic [3:0]    key_out;
  logic          valid;
  logic [ADDR_W:0] count;
  logic          overflow;
  modport master(output key_in, pressed_in, pop, clr_overflow,
                 input key_out, valid, count, overflow);
  modport slave(input key_in, pressed_in, pop, clr_overflow,
                output key_out, valid, count, overflow);
endinterface

// File: rtl/keypad_event_queue.sv
// keypad_event_queue: turns keypad presses and auto-repeats into events held in a FWFT queue
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of keypad_event_queue_if (key/pressed in, pop/clear in,
//           head key, valid, count and sticky overflow out)
module keypad_event_queue #(
  parameter int DEPTH        = 4,
  parameter int ADDR_W       = 2,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic rst_n,
  keypad_event_queue_if.slave bus
);
  typedef enum logic {IDLE, HELD} state_t;
  localparam logic [CNT_W-1:0] RD_M1 = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_M1 = CNT_W'(REPEAT_RATE - 1);
  state_t state_q;
  logic [3:0] key_q;
  logic [CNT_W-1:0] hcnt_q;
  logic rep_q;
  logic [ADDR_W:0] rd_q, wr_q;
  logic ovf_q;
  logic [3:0] mem_q [DEPTH];
  logic same, new_press, fire, push, full, do_pop, do_push, ovf_set;
  // A repeat fire pushes key_d, which equals key_in whenever "same" holds,
  // so the write data is always key_in.
  always_comb begin
    same      = bus.pressed_in && state_q == HELD && bus.key_in == key_q;
    new_press = bus.pressed_in && (state_q == IDLE || bus.key_in != key_q);
    fire      = same && REPEAT_DELAY != 0 && hcnt_q == (rep_q ? RR_M1 : RD_M1);
    push      = new_press || fire;
    full      = wr_q[ADDR_W] != rd_q[ADDR_W] && wr_q[ADDR_W-1:0] == rd_q[ADDR_W-1:0];
    do_pop    = bus.pop && bus.valid;
    do_push   = push && (!full || do_pop);
    ovf_set   = push && full && !do_pop;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      hcnt_q  <= '0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= bus.pressed_in ? HELD : IDLE;
      if (bus.pressed_in) key_q <= bus.key_in;
      if (push) hcnt_q <= '0;
      else if (same && REPEAT_DELAY != 0 && hcnt_q != '1) hcnt_q <= hcnt_q + 1'b1;
      rep_q <= fire ? 1'b1 : new_press ? 1'b0 : rep_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_pop) rd_q <= rd_q + 1'b1;
      if (do_push) wr_q <= wr_q + 1'b1;
      ovf_q <= ovf_set || (ovf_q && !bus.clr_overflow);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q[ADDR_W-1:0]] <= bus.key_in;
  assign bus.count    = wr_q - rd_q;
  assign bus.valid    = wr_q != rd_q;
  assign bus.key_out  = bus.valid ? mem_q[rd_q[ADDR_W-1:0]] : 4'h0;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_keypad_event_queue.sv
// tb_keypad_event_queue: directed plus randomized check of keypad_event_queue against a queue model
module tb_keypad_event_queue;
  localparam int DEPTH = 4, ADDR_W = 2, RD = 50, RR = 10;
  logic clk = 1'b0, rst_n = 1'b0;
  int errors = 0, checks = 0, npop = 0;
  logic [3:0] mq[$];
  logic m_held = 1'b0, m_ovf = 1'b0;
  logic [3:0] m_key = 4'h0;
  int m_t = 0;
  keypad_event_queue_if #(.ADDR_W(ADDR_W)) bus ();
  keypad_event_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .REPEAT_DELAY(RD),
                       .REPEAT_RATE(RR), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    m_held = 1'b0;
    m_ovf = 1'b0;
    m_key = 4'h0;
    m_t = 0;
  endtask
  task automatic model_edge(input logic p, input logic [3:0] k, input logic po, input logic c);
    logic ev, pop_ok, set;
    int sz;
    ev = 1'b0;
    if (p) begin
      if (!m_held || k != m_key) begin
        ev = 1'b1;
        m_t = 0;
      end else begin
        m_t++;
        if (RD != 0 && m_t >= RD && (m_t - RD) % RR == 0) ev = 1'b1;
      end
      m_key = k;
    end
    m_held = p;
    sz = mq.size();
    pop_ok = po && sz > 0;
    if (pop_ok) begin
      void'(mq.pop_front());
      npop++;
    end
    set = ev && sz == DEPTH && !pop_ok;
    if (ev && !set) mq.push_back(k);
    m_ovf = set ? 1'b1 : (c ? 1'b0 : m_ovf);
  endtask
  task automatic compare();
    check("valid", int'(bus.valid), int'(mq.size() > 0));
    check("count", int'(bus.count), mq.size());
    check("key_out", int'(bus.key_out), mq.size() > 0 ? int'(mq[0]) : 0);
    check("overflow", int'(bus.overflow), int'(m_ovf));
  endtask
  task automatic step(input logic p, input logic [3:0] k, input logic po, input logic c);
    @(negedge clk);
    bus.pressed_in = p;
    bus.key_in = k;
    bus.pop = po;
    bus.clr_overflow = c;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(p, k, po, c);
    #1 compare();
  endtask
  task automatic drain();
    repeat (DEPTH + 1) step(1'b0, 4'h0, 1'b1, 1'b1);
  endtask
  initial begin
    logic p, po, c;
    logic [3:0] k;
    bus.pressed_in = 1'b0;
    bus.key_in = 4'h0;
    bus.pop = 1'b0;
    bus.clr_overflow = 1'b0;
    repeat (3) step(1'b0, 4'h0, 1'b0, 1'b0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_count", int'(bus.count), 0);
    rst_n = 1'b1;
    repeat (10) step(1'b0, 4'h0, 1'b0, 1'b0);
    repeat (20) step(1'b1, 4'h5, 1'b0, 1'b0);
    check("single_count", int'(bus.count), 1);
    check("single_key", int'(bus.key_out), 5);
    drain();
    npop = 0;
    repeat (80) step(1'b1, 4'h2, mq.size() > 0, 1'b0);
    repeat (5) step(1'b0, 4'h2, mq.size() > 0, 1'b0);
    check("repeat_pops", npop, 4);
    repeat (5) step(1'b1, 4'h1, 1'b0, 1'b0);
    repeat (60) step(1'b1, 4'h3, 1'b0, 1'b0);
    check("change_count", int'(bus.count), 3);
    check("change_head", int'(bus.key_out), 1);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check("change_second", int'(bus.key_out), 3);
    drain();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 4'(i), 1'b0, 1'b0);
      step(1'b0, 4'(i), 1'b0, 1'b0);
    end
    check("ovf_count", int'(bus.count), 4);
    check("ovf_flag", int'(bus.overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_order", int'(bus.key_out), i);
      step(1'b0, 4'h0, 1'b1, 1'b0);
    end
    check("ovf_sticky", int'(bus.overflow), 1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check("ovf_clear", int'(bus.overflow), 0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 4'(i), 1'b0, 1'b0);
      step(1'b0, 4'(i), 1'b0, 1'b0);
    end
    step(1'b1, 4'h9, 1'b1, 1'b0);
    check("full_pp_count", int'(bus.count), 4);
    check("full_pp_ovf", int'(bus.overflow), 0);
    check("full_pp_head", int'(bus.key_out), 2);
    drain();
    step(1'b1, 4'h6, 1'b1, 1'b0);
    check("empty_pp_count", int'(bus.count), 1);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 7; i <= 8; i++) begin
      step(1'b1, 4'(i), 1'b0, 1'b0);
      step(1'b0, 4'(i), 1'b0, 1'b0);
    end
    check("pre_rst_count", int'(bus.count), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(bus.valid), 0);
    check("arst_count", int'(bus.count), 0);
    check("arst_key", int'(bus.key_out), 0);
    model_reset();
    step(1'b1, 4'h7, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 4'h7, 1'b0, 1'b0);
    check("arst_fresh_count", int'(bus.count), 1);
    check("arst_fresh_key", int'(bus.key_out), 7);
    p = 1'b0;
    k = 4'h0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) p = ~p;
      if ($urandom_range(29) == 0) k = 4'($urandom);
      po = $urandom_range(3) == 0;
      c = $urandom_range(49) == 0;
      step(p, k, po, c);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
